// File: rtl/ht_cmd_mux.sv
// Multi-channel front end for the hash table: round-robin command arbitration with a
// registered issue stage, plus an order FIFO that steers in-order results back to their issuers.
module ht_cmd_mux #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned KEY_WIDTH    = 32,
    parameter int unsigned VALUE_WIDTH  = 16,
    parameter int unsigned OPCODE_WIDTH = 2,
    parameter int unsigned RES_WIDTH    = 64,
    parameter int unsigned MAX_INFLIGHT = 16,
    parameter int unsigned CMD_WIDTH    = OPCODE_WIDTH + KEY_WIDTH + VALUE_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [CHANNELS*CMD_WIDTH-1:0] cmd_i,
    input  logic [CHANNELS-1:0]           cmd_valid_i,
    output logic [CHANNELS-1:0]           cmd_ready_o,
    output logic [CMD_WIDTH-1:0]          ht_cmd_o,
    output logic                          ht_cmd_valid_o,
    input  logic                          ht_cmd_ready_i,
    input  logic [RES_WIDTH-1:0]          ht_res_i,
    input  logic                          ht_res_valid_i,
    output logic                          ht_res_ready_o,
    output logic [RES_WIDTH-1:0]          res_o,
    output logic [CHANNELS-1:0]           res_valid_o,
    input  logic [CHANNELS-1:0]           res_ready_i,
    output logic [$clog2(MAX_INFLIGHT):0] inflight_o,
    output logic                          err_orphan_res_o
);

    localparam int unsigned CH_W  = $clog2(CHANNELS);
    localparam int unsigned PTR_W = $clog2(MAX_INFLIGHT);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [CH_W-1:0]      fifo_q [MAX_INFLIGHT];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     inflight_q, inflight_d;
    logic [CH_W-1:0]      rr_q, rr_d;
    logic [CMD_WIDTH-1:0] ht_cmd_q, ht_cmd_d;
    logic                 ht_cmd_valid_q, ht_cmd_valid_d;
    logic                 err_q, err_d;
    logic                 started_q;

    logic                 fifo_empty;
    logic [CH_W-1:0]      head;
    logic                 slot_free;
    logic                 issue_ok;
    logic                 push;
    logic                 pop;
    logic                 grant_found;
    logic [CH_W-1:0]      grant_idx;
    int unsigned          cand;

    assign ht_cmd_o         = ht_cmd_q;
    assign ht_cmd_valid_o   = ht_cmd_valid_q;
    assign inflight_o       = inflight_q;
    assign err_orphan_res_o = err_q;

    // Result steering: in-order results go to the channel at the FIFO head.
    always_comb begin
        res_o          = ht_res_i;
        fifo_empty     = (inflight_q == '0);
        head           = fifo_q[rd_ptr_q];
        res_valid_o    = '0;
        ht_res_ready_o = 1'b1;
        pop            = 1'b0;
        if (!fifo_empty) begin
            res_valid_o[head] = ht_res_valid_i;
            ht_res_ready_o    = res_ready_i[head];
            pop               = ht_res_valid_i && res_ready_i[head];
        end
    end

    // Round-robin search starting at rr_q; a same-cycle pop frees a slot at the limit.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            cand = (32'(rr_q) + i) % CHANNELS;
            if (!grant_found && cmd_valid_i[CH_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'(cand);
            end
        end
        slot_free   = !ht_cmd_valid_q || ht_cmd_ready_i;
        issue_ok    = started_q && slot_free &&
                      ((inflight_q - CNT_W'(pop)) < CNT_W'(MAX_INFLIGHT));
        push        = issue_ok && grant_found;
        cmd_ready_o = '0;
        if (push) begin
            cmd_ready_o[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ht_cmd_d       = ht_cmd_q;
        ht_cmd_valid_d = ht_cmd_valid_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        rr_d           = rr_q;
        inflight_d     = inflight_q;
        err_d          = err_q | (ht_res_valid_i && fifo_empty);
        if (push) begin
            ht_cmd_d       = cmd_i[32'(grant_idx)*CMD_WIDTH +: CMD_WIDTH];
            ht_cmd_valid_d = 1'b1;
            wr_ptr_d       = wr_ptr_q + PTR_W'(1);
            rr_d           = (grant_idx == CH_W'(CHANNELS - 1)) ? '0 : grant_idx + CH_W'(1);
        end else if (slot_free) begin
            ht_cmd_valid_d = 1'b0;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ht_cmd_q       <= '0;
            ht_cmd_valid_q <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            inflight_q     <= '0;
            rr_q           <= '0;
            err_q          <= 1'b0;
            started_q      <= 1'b0;
        end else begin
            ht_cmd_q       <= ht_cmd_d;
            ht_cmd_valid_q <= ht_cmd_valid_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            inflight_q     <= inflight_d;
            rr_q           <= rr_d;
            err_q          <= err_d;
            started_q      <= 1'b1;
        end
    end

    // Order FIFO storage; validity is tracked by the reset pointers and counter.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= grant_idx;
        end
    end

endmodule

// File: tb/tb_ht_cmd_mux.sv
// Directed bench for ht_cmd_mux: a vector table for single-cycle behaviour and
// hand-written sequences for fairness, the inflight limit and reset.
module tb_ht_cmd_mux;

    localparam int unsigned CH   = 4;
    localparam int unsigned CW   = 50;
    localparam int unsigned RW   = 64;
    localparam int unsigned MAXI = 16;

    logic           clk = 1'b0;
    logic           rst_n_i;
    logic [CH*CW-1:0] cmd_i;
    logic [CH-1:0]  cmd_valid_i;
    logic [CH-1:0]  cmd_ready_o;
    logic [CW-1:0]  ht_cmd_o;
    logic           ht_cmd_valid_o;
    logic           ht_cmd_ready_i;
    logic [RW-1:0]  ht_res_i;
    logic           ht_res_valid_i;
    logic           ht_res_ready_o;
    logic [RW-1:0]  res_o;
    logic [CH-1:0]  res_valid_o;
    logic [CH-1:0]  res_ready_i;
    logic [4:0]     inflight_o;
    logic           err_orphan_res_o;

    int checks = 0;
    int errors = 0;
    int step_no = 0;

    ht_cmd_mux dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n_i),
        .cmd_i            (cmd_i),
        .cmd_valid_i      (cmd_valid_i),
        .cmd_ready_o      (cmd_ready_o),
        .ht_cmd_o         (ht_cmd_o),
        .ht_cmd_valid_o   (ht_cmd_valid_o),
        .ht_cmd_ready_i   (ht_cmd_ready_i),
        .ht_res_i         (ht_res_i),
        .ht_res_valid_i   (ht_res_valid_i),
        .ht_res_ready_o   (ht_res_ready_o),
        .res_o            (res_o),
        .res_valid_o      (res_valid_o),
        .res_ready_i      (res_ready_i),
        .inflight_o       (inflight_o),
        .err_orphan_res_o (err_orphan_res_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cv;
        logic       hcr;
        logic       hrv;
        logic [3:0] rr;
        logic [3:0] ecr;
        logic [3:0] erv;
        logic       ehrr;
        logic       ehv;
        int         ech;
        int         einf;
        logic       eerr;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [CW-1:0] cmd_of(input int ch);
        return {2'(ch + 1), 32'h0100_0000 + 32'(ch), 16'h1234 + 16'(ch)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %0h expected %0h", name, step_no, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] cv, input logic hcr, input logic hrv, input logic [3:0] rr);
        step_no++;
        cmd_valid_i    = cv;
        ht_cmd_ready_i = hcr;
        ht_res_valid_i = hrv;
        res_ready_i    = rr;
        ht_res_i       = 64'hC0DE_0000_0000_0000 | 64'(step_no);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] cv, input logic hcr, input logic hrv, input logic [3:0] rr,
                       input logic [3:0] ecr, input logic [3:0] erv, input logic ehrr,
                       input logic ehv, input int ech, input int einf, input logic eerr);
        vecs.push_back('{cv, hcr, hrv, rr, ecr, erv, ehrr, ehv, ech, einf, eerr});
    endtask

    int q[$];
    int gcnt[CH];
    int rcnt[CH];
    int acc;
    logic hrv;

    initial begin
        //   cv      hcr  hrv  rr       ecr      erv      ehrr  ehv ech inf err
        add(4'b0001, 1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b1, 1'b1, 0, 1, 1'b0);
        add(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 0, 1, 1'b0);
        add(4'b0000, 1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, 0, 0, 1'b0);
        add(4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b1, 1'b1, 1, 1, 1'b0);
        add(4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b1, 2, 2, 1'b0);
        add(4'b1111, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2, 2, 1'b0);
        add(4'b1111, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2, 2, 1'b0);
        add(4'b1111, 1'b1, 1'b1, 4'b0010, 4'b1000, 4'b0010, 1'b1, 1'b1, 3, 2, 1'b0);
        add(4'b1001, 1'b1, 1'b1, 4'b0000, 4'b0001, 4'b0100, 1'b0, 1'b1, 0, 3, 1'b0);
        add(4'b1001, 1'b1, 1'b1, 4'b0100, 4'b1000, 4'b0100, 1'b1, 1'b1, 3, 3, 1'b0);
        add(4'b0000, 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b1000, 1'b1, 1'b0, 3, 2, 1'b0);
        add(4'b0000, 1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b0, 3, 1, 1'b0);
        add(4'b0000, 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b1000, 1'b1, 1'b0, 3, 0, 1'b0);
        add(4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 3, 0, 1'b1);
        add(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 3, 0, 1'b1);

        for (int n = 0; n < CH; n++) cmd_i[n*CW +: CW] = cmd_of(n);
        rst_n_i = 1'b0;
        drive(4'b0000, 1'b0, 1'b0, 4'b0000);
        #12;
        chk("rst_ht_cmd_valid", 64'(ht_cmd_valid_o), 64'd0);
        chk("rst_ht_cmd", 64'(ht_cmd_o), 64'd0);
        chk("rst_inflight", 64'(inflight_o), 64'd0);
        chk("rst_err", 64'(err_orphan_res_o), 64'd0);
        cmd_valid_i = 4'b0001;
        rst_n_i     = 1'b1;
        #1;
        chk("ready_before_first_edge", 64'(cmd_ready_o), 64'd0);
        tick();

        foreach (vecs[k]) begin
            drive(vecs[k].cv, vecs[k].hcr, vecs[k].hrv, vecs[k].rr);
            #3;
            chk("tbl_cmd_ready", 64'(cmd_ready_o), 64'(vecs[k].ecr));
            chk("tbl_res_valid", 64'(res_valid_o), 64'(vecs[k].erv));
            chk("tbl_ht_res_ready", 64'(ht_res_ready_o), 64'(vecs[k].ehrr));
            chk("tbl_res_passthru", res_o, 64'hC0DE_0000_0000_0000 | 64'(step_no));
            tick();
            chk("tbl_ht_cmd_valid", 64'(ht_cmd_valid_o), 64'(vecs[k].ehv));
            chk("tbl_ht_cmd", 64'(ht_cmd_o), 64'(cmd_of(vecs[k].ech)));
            chk("tbl_inflight", 64'(inflight_o), 64'(vecs[k].einf));
            chk("tbl_err", 64'(err_orphan_res_o), 64'(vecs[k].eerr));
        end

        // Fairness: 100 back-to-back grants with results returned one cycle behind.
        for (int i = 0; i < 100; i++) begin
            hrv = (q.size() > 0);
            drive(4'b1111, 1'b1, hrv, 4'b1111);
            #3;
            chk("rr_grant", 64'(cmd_ready_o), 64'(4'b0001 << (i % 4)));
            for (int c = 0; c < CH; c++) begin
                if (cmd_ready_o[c]) gcnt[c]++;
                if (res_valid_o[c]) rcnt[c]++;
            end
            if (hrv) begin
                chk("rr_res_route", 64'(res_valid_o), 64'(4'b0001 << q[0]));
                void'(q.pop_front());
            end
            q.push_back(i % 4);
            tick();
            chk("rr_ht_cmd", 64'(ht_cmd_o), 64'(cmd_of(i % 4)));
        end
        for (int k = 0; k < 20 && q.size() > 0; k++) begin
            drive(4'b0000, 1'b1, 1'b1, 4'b1111);
            #3;
            chk("drain_res_route", 64'(res_valid_o), 64'(4'b0001 << q[0]));
            for (int c = 0; c < CH; c++) if (res_valid_o[c]) rcnt[c]++;
            void'(q.pop_front());
            tick();
        end
        chk("drain_inflight", 64'(inflight_o), 64'd0);
        for (int c = 0; c < CH; c++) begin
            chk("rr_grant_count", 64'(gcnt[c]), 64'd25);
            chk("rr_result_count", 64'(rcnt[c]), 64'd25);
        end

        // Inflight limit with the result path stalled.
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            drive(4'b1111, 1'b1, 1'b0, 4'b1111);
            #3;
            if (cmd_ready_o != 4'b0000) acc++;
            tick();
        end
        chk("limit_accepted", 64'(acc), 64'(MAXI));
        chk("limit_inflight", 64'(inflight_o), 64'(MAXI));
        drive(4'b1111, 1'b1, 1'b0, 4'b1111);
        #3;
        chk("limit_ready_low", 64'(cmd_ready_o), 64'd0);
        tick();
        drive(4'b1111, 1'b1, 1'b1, 4'b1111);
        #3;
        chk("limit_pop_reenable", 64'(cmd_ready_o), 64'(4'b0001));
        chk("limit_pop_res", 64'(res_valid_o), 64'(4'b0001));
        tick();
        chk("limit_inflight_held", 64'(inflight_o), 64'(MAXI));

        // Asynchronous reset in the middle of traffic (orphan flag was set earlier).
        drive(4'b1111, 1'b1, 1'b0, 4'b1111);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("arst_ht_cmd_valid", 64'(ht_cmd_valid_o), 64'd0);
        chk("arst_ht_cmd", 64'(ht_cmd_o), 64'd0);
        chk("arst_inflight", 64'(inflight_o), 64'd0);
        chk("arst_err", 64'(err_orphan_res_o), 64'd0);
        chk("arst_cmd_ready", 64'(cmd_ready_o), 64'd0);
        #3;
        rst_n_i = 1'b1;
        #1;
        chk("arst_ready_before_edge", 64'(cmd_ready_o), 64'd0);
        tick();
        chk("arst_ready_after_edge", 64'(cmd_ready_o), 64'(4'b0001));
        drive(4'b0000, 1'b1, 1'b1, 4'b0000);
        #3;
        chk("orphan_res_valid", 64'(res_valid_o), 64'd0);
        chk("orphan_ht_res_ready", 64'(ht_res_ready_o), 64'd1);
        tick();
        chk("orphan_err_set", 64'(err_orphan_res_o), 64'd1);
        drive(4'b0000, 1'b1, 1'b0, 4'b0000);
        tick();
        chk("orphan_err_sticky", 64'(err_orphan_res_o), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ht_cmd_mux.md
Name: ht_cmd_mux

Overview:
- Multi-channel front end for hash_table_top.
- Arbitrates CHANNELS independent command streams onto the single ht_cmd interface, using round-robin with a registered output stage.
- Records the issuing channel of every accepted command in an order FIFO.
- The hash table returns results in command order, so each result is steered back to the channel that issued it; this lets several clients share one table.

Parameters:
CHANNELS, 4, number of client command/result channels (2..16)
KEY_WIDTH, 32, key field width
VALUE_WIDTH, 16, value field width
OPCODE_WIDTH, 2, opcode field width
RES_WIDTH, 64, width of packed result word (opaque to this block)
MAX_INFLIGHT, 16, order FIFO depth; max commands issued but not yet answered (power of 2)
CMD_WIDTH, OPCODE_WIDTH+KEY_WIDTH+VALUE_WIDTH, packed command width (derived)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
cmd_i  in  CHANNELS*CMD_WIDTH  per-channel packed commands; channel n at bits [n*CMD_WIDTH +: CMD_WIDTH]
cmd_valid_i  in  CHANNELS  per-channel command valid
cmd_ready_o  out  CHANNELS  per-channel command accept
ht_cmd_o  out  CMD_WIDTH  command to hash table (registered)
ht_cmd_valid_o  out  1  command valid (registered)
ht_cmd_ready_i  in  1  hash table accepts command
ht_res_i  in  RES_WIDTH  result from hash table
ht_res_valid_i  in  1  result valid
ht_res_ready_o  out  1  result accept
res_o  out  RES_WIDTH  result broadcast to all channels (= ht_res_i)
res_valid_o  out  CHANNELS  one-hot result valid for the owning channel
res_ready_i  in  CHANNELS  per-channel result ready
inflight_o  out  $clog2(MAX_INFLIGHT)+1  commands issued, result not yet returned
err_orphan_res_o  out  1  sticky: a result arrived with no command in flight

Behaviour:

Reset (async assert, sync release): the following clear to 0:
- ht_cmd_valid_o, ht_cmd_o
- FIFO pointers, inflight_o
- err_orphan_res_o
- rr pointer

After reset:
- cmd_ready_o is 0 until the first clock edge after release.
- Any in-flight bookkeeping is discarded when reset asserts mid-operation.

Output slot:
- slot_free = !ht_cmd_valid_o || ht_cmd_ready_i.
- Issue is allowed when slot_free && (inflight_o < MAX_INFLIGHT, counted after this cycle's pop).

Arbitration:
- Round-robin over cmd_valid_i, starting at rr pointer.
- The winner gets cmd_ready_o[w] = 1, only when issue is allowed; all other bits are 0.
- On accept:
  - ht_cmd_o <= cmd_i[w]; ht_cmd_valid_o <= 1.
  - Push w into the order FIFO.
  - rr <= (w+1) mod CHANNELS.
- If slot_free with no accept, ht_cmd_valid_o <= 0.
- ht_cmd_o/valid are held stable while valid && !ready.
- Latency is 1 cycle from channel handshake to ht_cmd_valid_o.
- Full throughput: 1 command/cycle.

Inflight accounting:
- A command counts as in flight from the channel handshake cycle until its result handshake.
- Push without pop: +1. Pop without push: -1. Push and pop in the same cycle: unchanged.
- At inflight_o == MAX_INFLIGHT, all cmd_ready_o = 0; a pop in that same cycle re-enables issue in that cycle.

Result return:
- head = FIFO head channel id.
- res_valid_o[head] = ht_res_valid_i && !empty; all other bits are 0.
- ht_res_ready_o = empty ? 1 : res_ready_i[head].
- Pop on ht_res_valid_i && ht_res_ready_o && !empty.
- The result path is combinational: zero-latency pass-through.

Orphan result:
- Condition: ht_res_valid_i while the FIFO is empty.
- The result is consumed (ready = 1), dropped (no res_valid_o), and err_orphan_res_o <= 1 until reset.

Backpressure:
- A channel not ready for its result stalls all results (in-order). Commands may continue issuing until the inflight limit.

Pointers and counter:
- FIFO pointers wrap modulo MAX_INFLIGHT.
- The counter is wide enough to hold MAX_INFLIGHT exactly.

Test Plan:
1. Single channel: ch0 sends INSERT key 32'h01000000 value 16'h1234 → ht_cmd_valid_o=1 next cycle with that command. The bench returns a result after 3 cycles → res_valid_o=4'b0001; inflight_o goes 0→1→0.
2. Round-robin fairness: all 4 channels hold valid continuously, ready=1 → grant order 0,1,2,3,0,1… Each channel receives exactly 25 of 100 issued commands, and results are routed to the matching one-hot res_valid_o in order.
3. Inflight limit: MAX_INFLIGHT=16 with the result path stalled → exactly 16 commands accepted, then cmd_ready_o=0 and inflight_o=16. Releasing one result → one new command accepted in the same cycle; inflight_o stays 16.
4. Output backpressure: ht_cmd_ready_i=0 for 5 cycles while valid → ht_cmd_o stable, cmd_ready_o=0. Deasserting the stall → the held command is consumed and the next command loads in the same cycle.
5. Result stall: result owned by ch2 while res_ready_i[2]=0 → ht_res_ready_o=0 and res_valid_o=4'b0100 held. Other channels keep issuing until the limit.
6. Orphan result plus reset: ht_res_valid_i with no command in flight → ht_res_ready_o=1, res_valid_o=0, err_orphan_res_o=1 (sticky). Asserting rst_n_i=0 mid-traffic → all outputs clear asynchronously and inflight_o=0.
